// File: rtl/assoc_cache.sv
// Set-associative write-through, no-write-allocate cache with round-robin replacement.
// Loads hit combinationally; misses fetch one word, stores always write through to memory.
module assoc_cache #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SETS  = 4,
  parameter int unsigned WAYS  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cache_enable_i,
  input  logic             write_enable_i,
  input  logic             byte_op_i,
  input  logic [WIDTH-1:0] address_i,
  input  logic [WIDTH-1:0] write_data_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             stall_o,
  output logic             mem_req_o,
  input  logic             mem_ack_i,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic [WIDTH-1:0] mem_incoming_data_i
);

  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = WIDTH - 2 - IW;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_e;

  state_e state_q, state_d;

  logic [1:0]    offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;

  assign offset = address_i[1:0];
  assign index  = address_i[2 +: IW];
  assign tag    = address_i[WIDTH-1 -: TW];

  logic             valid_q [SETS][WAYS];
  logic [TW-1:0]    tag_q   [SETS][WAYS];
  logic [WIDTH-1:0] data_q  [SETS][WAYS];
  logic [WW-1:0]    ptr_q   [SETS];

  logic             hit;
  logic [WW-1:0]    hit_way;
  logic [WIDTH-1:0] hit_data;
  logic             has_invalid;
  logic [WW-1:0]    victim;
  logic [7:0]       hit_lane;
  logic [WIDTH-1:0] merged_data;
  logic             fill_en;
  logic             update_en;

  // Tag match and victim choice within the indexed set
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    hit_data    = '0;
    has_invalid = 1'b0;
    victim      = ptr_q[index];
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit && valid_q[index][w] && (tag_q[index][w] == tag)) begin
        hit      = 1'b1;
        hit_way  = WW'(w);
        hit_data = data_q[index][w];
      end
      if (!has_invalid && !valid_q[index][w]) begin
        has_invalid = 1'b1;
        victim      = WW'(w);
      end
    end
  end

  // Byte lane extraction for loads and lane merge for byte stores
  always_comb begin
    merged_data = hit_data;
    case (offset)
      2'd0: begin hit_lane = hit_data[7:0];   merged_data[7:0]   = write_data_i[7:0]; end
      2'd1: begin hit_lane = hit_data[15:8];  merged_data[15:8]  = write_data_i[7:0]; end
      2'd2: begin hit_lane = hit_data[23:16]; merged_data[23:16] = write_data_i[7:0]; end
      default: begin hit_lane = hit_data[31:24]; merged_data[31:24] = write_data_i[7:0]; end
    endcase
    if (!byte_op_i) merged_data = write_data_i;
  end

  always_comb begin
    state_d            = state_q;
    stall_o            = 1'b0;
    read_data_o        = '0;
    mem_req_o          = 1'b0;
    mem_write_enable_o = 1'b0;
    mem_byte_op_o      = 1'b0;
    mem_address_o      = '0;
    mem_write_data_o   = '0;
    fill_en            = 1'b0;
    update_en          = 1'b0;
    case (state_q)
      IDLE: begin
        if (cache_enable_i) begin
          if (write_enable_i) begin
            stall_o = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            read_data_o = byte_op_i ? WIDTH'(hit_lane) : hit_data;
          end else begin
            stall_o = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        stall_o       = 1'b1;
        mem_req_o     = 1'b1;
        mem_address_o = {address_i[WIDTH-1:2], 2'b00};
        if (mem_ack_i) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        // Release the core on the ack cycle so the held store is not reissued
        stall_o            = !mem_ack_i;
        mem_req_o          = 1'b1;
        mem_write_enable_o = 1'b1;
        mem_byte_op_o      = byte_op_i;
        mem_address_o      = address_i;
        mem_write_data_o   = write_data_i;
        if (mem_ack_i) begin
          update_en = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int s = 0; s < int'(SETS); s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[index][victim] <= 1'b1;
        ptr_q[index]           <= (WAYS > 1) ? WW'(ptr_q[index] + 1'b1) : '0;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits guard them
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[index][victim]  <= tag;
      data_q[index][victim] <= mem_incoming_data_i;
    end else if (update_en) begin
      data_q[index][hit_way] <= merged_data;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: drives core accesses, emulates a fixed-latency memory,
// and compares stalls, load data and memory-side signals against hand-computed values.
module tb_assoc_cache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cache_enable_i;
  logic        write_enable_i;
  logic        byte_op_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [31:0] mem_address_o;
  logic [31:0] mem_write_data_o;
  logic        mem_write_enable_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_incoming_data_i;

  assoc_cache #(.WIDTH(32), .SETS(4), .WAYS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cache_enable_i(cache_enable_i), .write_enable_i(write_enable_i),
    .byte_op_i(byte_op_i), .address_i(address_i), .write_data_i(write_data_i),
    .read_data_o(read_data_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
    .mem_write_enable_o(mem_write_enable_o), .mem_byte_op_o(mem_byte_op_o),
    .mem_incoming_data_i(mem_incoming_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  int          acc_stalls;
  int          acc_reqs;
  logic [31:0] acc_rdata;
  logic [31:0] acc_maddr;
  logic [31:0] acc_mwdata;
  logic        acc_mwe;
  logic        acc_mbyte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One core access starting at a negedge; memory acks after lat full request cycles
  task automatic access(input logic we, input logic bop, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input logic [31:0] mdata);
    bit done = 0;
    cache_enable_i      = 1'b1;
    write_enable_i      = we;
    byte_op_i           = bop;
    address_i           = addr;
    write_data_i        = wd;
    mem_incoming_data_i = mdata;
    mem_ack_i           = 1'b0;
    acc_stalls = 0; acc_reqs = 0; acc_rdata = '0;
    acc_maddr = '0; acc_mwdata = '0; acc_mwe = 1'b0; acc_mbyte = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (mem_req_o) begin
        if (acc_reqs == 0) begin
          acc_maddr  = mem_address_o;
          acc_mwdata = mem_write_data_o;
          acc_mwe    = mem_write_enable_o;
          acc_mbyte  = mem_byte_op_o;
        end
        acc_reqs++;
        if (acc_reqs > lat) mem_ack_i = 1'b1;
      end
      #1;
      if (!stall_o) begin
        done      = 1;
        acc_rdata = read_data_o;
      end else begin
        acc_stalls++;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
    cache_enable_i = 1'b0;
    write_enable_i = 1'b0;
    byte_op_i      = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; cache_enable_i = 1'b0; write_enable_i = 1'b0; byte_op_i = 1'b0;
    address_i = '0; write_data_i = '0; mem_ack_i = 1'b0; mem_incoming_data_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_rdata", read_data_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Cold load: 1 idle + 3 wait + 1 ack cycle of stall
    access(1'b0, 1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF);
    check("cold_stalls", 32'(acc_stalls), 32'd5);
    check("cold_rdata", acc_rdata, 32'hDEAD_BEEF);
    check("cold_maddr", acc_maddr, 32'h10);
    check("cold_mwe", 32'(acc_mwe), 32'd0);

    access(1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h0);
    check("hit_stalls", 32'(acc_stalls), 32'd0);
    check("hit_rdata", acc_rdata, 32'hDEAD_BEEF);
    check("hit_reqs", 32'(acc_reqs), 32'd0);

    access(1'b0, 1'b1, 32'h13, 32'h0, 0, 32'h0);
    check("byte3_rdata", acc_rdata, 32'h0000_00DE);
    check("byte3_reqs", 32'(acc_reqs), 32'd0);
    access(1'b0, 1'b1, 32'h12, 32'h0, 0, 32'h0);
    check("byte2_rdata", acc_rdata, 32'h0000_00AD);

    // Byte store to lane 1 of a cached line; only bits [7:0] of the data matter
    access(1'b1, 1'b1, 32'h11, 32'h1234_56AA, 0, 32'h0);
    check("bst_stalls", 32'(acc_stalls), 32'd1);
    check("bst_mbyte", 32'(acc_mbyte), 32'd1);
    check("bst_mwe", 32'(acc_mwe), 32'd1);
    check("bst_maddr", acc_maddr, 32'h11);
    check("bst_mwdata", acc_mwdata, 32'h1234_56AA);
    access(1'b0, 1'b0, 32'h10, 32'h0, 0, 32'h0);
    check("bst_reload_stalls", 32'(acc_stalls), 32'd0);
    check("bst_reload_rdata", acc_rdata, 32'hDEAD_AAEF);

    // Three lines into set 0: the third fill evicts the oldest (0x10)
    access(1'b0, 1'b0, 32'h30, 32'h0, 1, 32'h3030_3030);
    check("fill30_stalls", 32'(acc_stalls), 32'd3);
    access(1'b0, 1'b0, 32'h50, 32'h0, 1, 32'h5050_5050);
    check("fill50_stalls", 32'(acc_stalls), 32'd3);
    check("fill50_rdata", acc_rdata, 32'h5050_5050);
    access(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h1111_1111);
    check("evict10_stalls", 32'(acc_stalls), 32'd3);
    check("evict10_rdata", acc_rdata, 32'h1111_1111);
    access(1'b0, 1'b0, 32'h50, 32'h0, 0, 32'h0);
    check("keep50_stalls", 32'(acc_stalls), 32'd0);
    check("keep50_rdata", acc_rdata, 32'h5050_5050);

    // Store miss writes through without allocating
    access(1'b1, 1'b0, 32'h70, 32'h0000_0077, 0, 32'h0);
    check("stmiss_mwe", 32'(acc_mwe), 32'd1);
    check("stmiss_maddr", acc_maddr, 32'h70);
    check("stmiss_mwdata", acc_mwdata, 32'h0000_0077);
    check("stmiss_mbyte", 32'(acc_mbyte), 32'd0);
    access(1'b0, 1'b0, 32'h70, 32'h0, 1, 32'h7070_7070);
    check("noalloc_stalls", 32'(acc_stalls), 32'd3);

    // Unaligned byte load miss fetches the aligned word
    access(1'b0, 1'b1, 32'h0E, 32'h0, 0, 32'h1122_3344);
    check("bmiss_maddr", acc_maddr, 32'h0C);
    check("bmiss_mbyte", 32'(acc_mbyte), 32'd0);
    check("bmiss_rdata", acc_rdata, 32'h0000_0022);

    // Reset during a fetch, followed by a stray ack
    cache_enable_i = 1'b1; write_enable_i = 1'b0; byte_op_i = 1'b0; address_i = 32'h90;
    begin : wait_fetch
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_i);
        #1;
        if (mem_req_o) disable wait_fetch;
      end
    end
    check("rst_fetch_entered", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1; cache_enable_i = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_incoming_data_i = 32'hBAD0_BAD0;
    #1;
    check("late_ack_mem_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("late_ack_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    access(1'b0, 1'b0, 32'h90, 32'h0, 1, 32'h9090_9090);
    check("postrst_90_stalls", 32'(acc_stalls), 32'd3);
    check("postrst_90_rdata", acc_rdata, 32'h9090_9090);
    access(1'b0, 1'b0, 32'h50, 32'h0, 0, 32'h5555_5555);
    check("postrst_50_stalls", 32'(acc_stalls), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
